// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate clock enable, h/v counters and registered
// sync/blank/coordinate outputs for a VGA DAC, plus a per-frame update strobe.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int CLK_DIV     = 2,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk,
  output logic       pixel_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] r_div_cnt;
  logic [9:0]    r_h_cnt;
  logic [9:0]    r_v_cnt;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic          r_video_on;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_vga_clk;
  logic          r_pixel_tick;
  logic          r_frame_tick;

  logic w_advance;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_hs_on;
  logic w_vs_on;

  always_comb begin
    w_advance = (r_div_cnt == DIV_LAST);
    w_h_wrap  = (r_h_cnt == H_LAST);
    w_v_wrap  = (r_v_cnt == V_LAST);
    w_hs_on   = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
    w_vs_on   = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt    <= '0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_video_on   <= 1'b0;
      r_hsync      <= ~SYNC_ACTIVE;
      r_vsync      <= ~SYNC_ACTIVE;
      r_vga_clk    <= 1'b0;
      r_pixel_tick <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_div_cnt    <= w_advance ? '0 : r_div_cnt + 1'b1;
      r_pixel_tick <= w_advance;
      r_vga_clk    <= (r_div_cnt >= DIV_HALF);

      if (w_advance) begin
        r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 10'd1;
        if (w_h_wrap) begin
          r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
        end
      end

      // Output stage samples the counters, so every output shares one clk of latency
      r_x          <= r_h_cnt;
      r_y          <= r_v_cnt;
      r_video_on   <= (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
      r_hsync      <= w_hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync      <= w_vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      // div_cnt==0 marks the first clk of a pixel, so the strobe fires only on entry
      r_frame_tick <= (r_h_cnt == 10'd0) && (r_v_cnt == V_ACT) && (r_div_cnt == '0);
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign video_on    = r_video_on;
  assign vga_blank_n = r_video_on;
  assign vga_sync_n  = 1'b0;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign vga_clk     = r_vga_clk;
  assign pixel_tick  = r_pixel_tick;
  assign frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny-raster instance
// (CLK_DIV=4, active-high sync) so whole frames and wraps fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic [9:0] xa, ya, xb, yb;
  logic von_a, hs_a, vs_a, bn_a, sn_a, vc_a, pt_a, ft_a;
  logic von_b, hs_b, vs_b, bn_b, sn_b, vc_b, pt_b, ft_b;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .x(xa), .y(ya), .video_on(von_a),
    .hsync(hs_a), .vsync(vs_a), .vga_blank_n(bn_a), .vga_sync_n(sn_a),
    .vga_clk(vc_a), .pixel_tick(pt_a), .frame_tick(ft_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(4), .SYNC_ACTIVE(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .x(xb), .y(yb), .video_on(von_b),
    .hsync(hs_b), .vsync(vs_b), .vga_blank_n(bn_b), .vga_sync_n(sn_b),
    .vga_clk(vc_b), .pixel_tick(pt_b), .frame_tick(ft_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // k = rising edges since reset was last sampled low (0 while in reset)
  int k_a = 0, k_b = 0;
  bit started = 1'b0;
  int a_epoch = 0, b_epoch = 0;

  always @(posedge clk) begin
    k_a     <= rst_a ? 0 : k_a + 1;
    k_b     <= rst_b ? 0 : k_b + 1;
    started <= 1'b1;
  end

  // Expected outputs from raster arithmetic: pixel p = (k-1)/div, x = p mod H_TOTAL, ...
  function automatic logic [27:0] model(int k, int ha, int hfp, int hsw, int hbp,
                                        int va, int vfp, int vsw, int vbp, int cd, bit sa);
    int ht, vt, p, hx, vy;
    bit von, hs, vs, vc, pt, ft;
    if (k == 0) return {10'd0, 10'd0, 1'b0, ~sa, ~sa, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    p   = (k - 1) / cd;
    hx  = p % ht;
    vy  = (p / ht) % vt;
    von = (hx < ha) && (vy < va);
    hs  = (hx >= ha + hfp && hx < ha + hfp + hsw) ? sa : ~sa;
    vs  = (vy >= va + vfp && vy < va + vfp + vsw) ? sa : ~sa;
    vc  = ((k - 1) % cd) >= cd / 2;
    pt  = (k % cd) == 0;
    ft  = (hx == 0) && (vy == va) && (((k - 1) % cd) == 0);
    return {10'(hx), 10'(vy), von, hs, vs, von, 1'b0, vc, pt, ft};
  endfunction

  task automatic check(string name, logic [27:0] act, logic [27:0] exp, int k);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d got x=%0d y=%0d von/hs/vs/bn/sn/vclk/ptick/ftick=%b required x=%0d y=%0d flags=%b",
               name, k, act[27:18], act[17:8], act[7:0], exp[27:18], exp[17:8], exp[7:0]);
    end
  endtask

  task automatic lit(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  // Measurements over the first line of A and the first frames of B
  int hs_low_a = 0, von_cnt_a = 0, hs_fall_x = -1, hs_rise_x = -1;
  bit hs_prev_a = 1'b1;
  int ft_k_b[$];
  int pix_cnt_b = 0;

  always @(negedge clk) begin
    if (started) begin
      check("dut_a", {xa, ya, von_a, hs_a, vs_a, bn_a, sn_a, vc_a, pt_a, ft_a},
            model(k_a, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0), k_a);
      check("dut_b", {xb, yb, von_b, hs_b, vs_b, bn_b, sn_b, vc_b, pt_b, ft_b},
            model(k_b, 8, 2, 3, 2, 4, 1, 2, 1, 4, 1'b1), k_b);
      if (a_epoch == 0 && k_a >= 1 && k_a <= 1600) begin
        if (!hs_a) hs_low_a++;
        if (von_a) von_cnt_a++;
        if (hs_prev_a && !hs_a && hs_fall_x < 0) hs_fall_x = int'(xa);
        if (!hs_prev_a && hs_a && hs_rise_x < 0) hs_rise_x = int'(xa);
      end
      hs_prev_a = hs_a;
      if (b_epoch == 0 && ft_b) ft_k_b.push_back(k_b);
      if (b_epoch == 0 && k_b >= 1 && k_b <= 480 && pt_b && von_b) pix_cnt_b++;
    end
  end

  initial begin
    int t;
    repeat (5) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    @(negedge clk);  // k=1
    lit("a_first_x", int'(xa), 0);
    lit("a_first_y", int'(ya), 0);
    lit("a_first_von", int'(von_a), 1);
    lit("a_first_hs", int'(hs_a), 1);
    lit("a_first_vs", int'(vs_a), 1);
    lit("a_first_ptick", int'(pt_a), 0);
    @(negedge clk);  // k=2
    lit("a_k2_ptick", int'(pt_a), 1);
    lit("a_k2_x", int'(xa), 0);
    @(negedge clk);  // k=3
    lit("a_k3_x", int'(xa), 1);
    lit("a_k3_ptick", int'(pt_a), 0);

    t = 0;
    while (!(xa == 10'd700 && ya == 10'd1) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    lit("a_reach_700_1_timeout", int'(t < 5000), 1);
    lit("a_hs_low_line", hs_low_a, 192);
    lit("a_von_line", von_cnt_a, 1280);
    lit("a_hs_fall_x", hs_fall_x, 656);
    lit("a_hs_rise_x", hs_rise_x, 752);
    lit("a_hs_at_700", int'(hs_a), 0);

    rst_a   = 1'b1;
    a_epoch = 1;
    @(negedge clk);
    lit("a_rst_x", int'(xa), 0);
    lit("a_rst_von", int'(von_a), 0);
    lit("a_rst_hs", int'(hs_a), 1);
    lit("a_rst_ftick", int'(ft_a), 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    lit("a_restart_von", int'(von_a), 1);
    lit("a_restart_x", int'(xa), 0);

    lit("b_ftick_count_ge2", int'(ft_k_b.size() >= 2), 1);
    if (ft_k_b.size() >= 2) begin
      lit("b_ftick_first_k", ft_k_b[0], 241);
      lit("b_ftick_period", ft_k_b[1] - ft_k_b[0], 480);
    end
    lit("b_active_pixels_frame", pix_cnt_b, 32);

    t = 0;
    while (!(xb == 10'd11 && yb == 10'd5) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    lit("b_reach_11_5_timeout", int'(t < 1000), 1);
    lit("b_hs_at_11_5", int'(hs_b), 1);
    lit("b_vs_at_11_5", int'(vs_b), 1);
    rst_b   = 1'b1;
    b_epoch = 1;
    @(negedge clk);
    lit("b_rst_hs", int'(hs_b), 0);
    lit("b_rst_vs", int'(vs_b), 0);
    lit("b_rst_y", int'(yb), 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    repeat (600) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
